// File: rtl/zuss_issue_wb.sv
// Register file, operand issue (E stage) and writeback around the external ZUSS ALU.
// Optional macro ZUSS_DIV0_TRAP_EN adds a sticky div0 output for op 3 with a zero divisor.
module zuss_issue_wb #(
   parameter int unsigned NREGS = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_op,
   input  logic [AW-1:0] in_rd,
   input  logic [AW-1:0] in_rs1,
   input  logic [AW-1:0] in_rs2,
   input  logic [DW-1:0] in_imm,
   input  logic          in_use_imm,
   input  logic          in_wen,
   input  logic          hold,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [4:0]    alu_op,
   input  logic [DW-1:0] alu_out,
   output logic          flag_z,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
`ifdef ZUSS_DIV0_TRAP_EN
   ,
   output logic          div0
`endif
);

   logic [DW-1:0] rf_q [NREGS];

   logic          e_v_q, e_v_d;
   logic          e_wen_q, e_wen_d;
   logic [AW-1:0] e_rd_q, e_rd_d;
   logic [4:0]    e_op_q, e_op_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic          flag_z_q, flag_z_d;

   logic          accept;
   logic          wb_fire;
   logic          rf_we;
   logic          fwd_en;
   logic          trap;
   logic [DW-1:0] src_a, src_b;

   assign in_ready = ~hold;
   assign accept   = in_valid & ~hold;
   assign wb_fire  = e_v_q & ~hold;

`ifdef ZUSS_DIV0_TRAP_EN
   logic div0_q, div0_d;

   assign trap   = (e_op_q == 5'd3) && (b_q == '0);
   assign div0_d = div0_q | (wb_fire & trap);
   assign div0   = div0_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div0_q <= 1'b0;
      end else begin
         div0_q <= div0_d;
      end
   end
`else
   assign trap = 1'b0;
`endif

   // A trapped divide produces no architectural result, so it must not be forwarded.
   assign fwd_en = e_v_q & e_wen_q & ~hold & ~trap;
   assign rf_we  = wb_fire & e_wen_q & (e_rd_q != '0) & ~trap;

   always_comb begin
      src_a = rf_q[in_rs1];
      if (in_rs1 == '0) begin
         src_a = '0;
      end else if (fwd_en && (e_rd_q == in_rs1)) begin
         src_a = alu_out;
      end
   end

   always_comb begin
      src_b = rf_q[in_rs2];
      if (in_rs2 == '0) begin
         src_b = '0;
      end else if (fwd_en && (e_rd_q == in_rs2)) begin
         src_b = alu_out;
      end
   end

   always_comb begin
      e_v_d    = e_v_q;
      e_wen_d  = e_wen_q;
      e_rd_d   = e_rd_q;
      e_op_d   = e_op_q;
      a_d      = a_q;
      b_d      = b_q;
      flag_z_d = flag_z_q;
      if (!hold) begin
         e_v_d = accept;
         if (accept) begin
            e_wen_d = in_wen;
            e_rd_d  = in_rd;
            e_op_d  = in_op;
            a_d     = src_a;
            b_d     = in_use_imm ? in_imm : src_b;
         end
         if (e_v_q && !trap) begin
            flag_z_d = (alu_out == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_v_q    <= 1'b0;
         e_wen_q  <= 1'b0;
         e_rd_q   <= '0;
         e_op_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         flag_z_q <= 1'b0;
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         e_v_q    <= e_v_d;
         e_wen_q  <= e_wen_d;
         e_rd_q   <= e_rd_d;
         e_op_q   <= e_op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         flag_z_q <= flag_z_d;
         if (rf_we) begin
            rf_q[e_rd_q] <= alu_out;
         end
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = e_op_q;
   assign flag_z   = flag_z_q;
   assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_zuss_issue_wb.sv
// Scoreboard bench for zuss_issue_wb with a behavioural ALU; honours ZUSS_DIV0_TRAP_EN.
module tb_zuss_issue_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_op = '0;
   logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        in_use_imm = 1'b0;
   logic        in_wen = 1'b0;
   logic        hold = 1'b0;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic        flag_z;
   logic [3:0]  dbg_addr = '0;
   logic [31:0] dbg_data;
`ifdef ZUSS_DIV0_TRAP_EN
   logic        div0;
   localparam bit Trap = 1'b1;
`else
   localparam bit Trap = 1'b0;
`endif

   always #5 clk = ~clk;

   zuss_issue_wb dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .in_use_imm (in_use_imm),
      .in_wen     (in_wen),
      .hold       (hold),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_out    (alu_out),
      .flag_z     (flag_z),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
`ifdef ZUSS_DIV0_TRAP_EN
      ,
      .div0       (div0)
`endif
   );

   // Behavioural ALU: 0 add, 1 sub, 3 divide (all-ones on zero divisor), 7 pass B, else xor.
   always_comb begin
      case (alu_op)
         5'd0:    alu_out = alu_a + alu_b;
         5'd1:    alu_out = alu_a - alu_b;
         5'd3:    alu_out = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
         5'd7:    alu_out = alu_b;
         default: alu_out = alu_a ^ alu_b;
      endcase
   end

   typedef struct {logic [31:0] a; logic [31:0] b; logic [4:0] op;} e_t;
   typedef struct {logic z; logic [3:0] rd; logic [31:0] data; logic chk; logic d0;} wb_t;
   typedef struct {logic kind; logic [3:0] addr; logic [31:0] data;} c_t;

   e_t  exp_e[$];
   wb_t exp_wb[$];
   c_t  exp_c[$];

   int total = 0;
   int bad   = 0;
   bit e_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic underflow(input string name);
      total++;
      bad++;
      $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
   endtask

   // Monitor: tracks handshake/writeback events and pops the matching expectations.
   always @(posedge clk) begin
      bit rs, hs, acc, wb;
      e_t  e;
      wb_t w;
      c_t  c;
      rs  = rst;
      hs  = hold;
      acc = in_valid && !hold && !rst;
      wb  = e_pend && !hold && !rst;
      if (rs) e_pend = 1'b0;
      else if (!hs) e_pend = acc;
      #1;
      check("in_ready", {31'd0, in_ready}, {31'd0, !hs});
      if (rs) begin
         check("rst_alu_a", alu_a, 32'd0);
         check("rst_alu_b", alu_b, 32'd0);
         check("rst_alu_op", {27'd0, alu_op}, 32'd0);
         check("rst_flag_z", {31'd0, flag_z}, 32'd0);
`ifdef ZUSS_DIV0_TRAP_EN
         check("rst_div0", {31'd0, div0}, 32'd0);
`endif
      end
      if (acc || (hs && !rs)) begin
         if (exp_e.size() == 0) underflow("e_stage");
         else begin
            e = exp_e.pop_front();
            check("alu_a", alu_a, e.a);
            check("alu_b", alu_b, e.b);
            check("alu_op", {27'd0, alu_op}, {27'd0, e.op});
         end
      end
      if (wb) begin
         if (exp_wb.size() == 0) underflow("writeback");
         else begin
            w = exp_wb.pop_front();
            check("wb_flag_z", {31'd0, flag_z}, {31'd0, w.z});
`ifdef ZUSS_DIV0_TRAP_EN
            check("wb_div0", {31'd0, div0}, {31'd0, w.d0});
`endif
            if (w.chk) begin
               dbg_addr = w.rd;
               #1;
               check("wb_reg", dbg_data, w.data);
            end
         end
      end
      if (exp_c.size() != 0) begin
         c = exp_c.pop_front();
         if (c.kind == 1'b0) begin
            dbg_addr = c.addr;
            #1;
            check("dbg_reg", dbg_data, c.data);
         end else begin
            check("flag_z", {31'd0, flag_z}, c.data);
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [3:0] rd, rs1, rs2,
                        input logic [31:0] imm, input logic use_imm, wen,
                        input logic [31:0] ea, eb, input logic push_wb,
                        input logic ez, input logic [31:0] edata, input logic chk,
                        input logic ed0);
      in_valid = 1'b1;
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_use_imm = use_imm; in_wen = wen;
      exp_e.push_back('{a: ea, b: eb, op: op});
      if (push_wb) exp_wb.push_back('{z: ez, rd: rd, data: edata, chk: chk, d0: ed0});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) exp_c.push_back('{kind: 1'b0, addr: 4'(i), data: 32'd0});
      exp_c.push_back('{kind: 1'b1, addr: 4'd0, data: 32'd0});
      idle(19);

      // Dependent pair: second instruction takes r1 via forwarding.
      issue(5'd0, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 1'b1, 32'd0, 32'd5, 1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
      issue(5'd0, 4'd2, 4'd1, 4'd0, 32'd3, 1'b1, 1'b1, 32'd5, 32'd3, 1'b1, 1'b0, 32'd8, 1'b1, 1'b0);
      idle(3);

      // Zero result, r0 write discard, rs2 forwarding, wen=0 still updates flag_z.
      issue(5'd1, 4'd3, 4'd1, 4'd1, 32'd0, 1'b0, 1'b1, 32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
      issue(5'd7, 4'd0, 4'd0, 4'd0, 32'd9, 1'b1, 1'b1, 32'd0, 32'd9, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      issue(5'd0, 4'd7, 4'd2, 4'd3, 32'd0, 1'b0, 1'b1, 32'd8, 32'd0, 1'b1, 1'b0, 32'd8, 1'b1, 1'b0);
      issue(5'd0, 4'd8, 4'd1, 4'd7, 32'd0, 1'b0, 1'b1, 32'd5, 32'd8, 1'b1, 1'b0, 32'd13, 1'b1, 1'b0);
      issue(5'd1, 4'd9, 4'd1, 4'd1, 32'd0, 1'b0, 1'b0, 32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
      idle(3);
      exp_c.push_back('{kind: 1'b0, addr: 4'd9, data: 32'd0});
      idle(2);

      // Hold for three cycles with op0 rd=4 in E and a competing instruction offered.
      issue(5'd0, 4'd4, 4'd0, 4'd0, 32'd11, 1'b1, 1'b1, 32'd0, 32'd11, 1'b1, 1'b0, 32'd11, 1'b1,
            1'b0);
      for (int i = 0; i < 3; i++) exp_e.push_back('{a: 32'd0, b: 32'd11, op: 5'd0});
      exp_c.push_back('{kind: 1'b0, addr: 4'd4, data: 32'd0});
      exp_c.push_back('{kind: 1'b1, addr: 4'd0, data: 32'd1});
      hold = 1'b1;
      in_valid = 1'b1; in_op = 5'd1; in_rd = 4'd10; in_rs1 = 4'd1; in_use_imm = 1'b1;
      repeat (3) @(negedge clk);
      hold = 1'b0;
      idle(3);

      // Reset while op0 rd=5 imm=7 sits in E: no writeback, everything cleared.
      issue(5'd0, 4'd5, 4'd0, 4'd0, 32'd7, 1'b1, 1'b1, 32'd0, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_c.push_back('{kind: 1'b0, addr: 4'd5, data: 32'd0});
      exp_c.push_back('{kind: 1'b0, addr: 4'd4, data: 32'd0});
      exp_c.push_back('{kind: 1'b1, addr: 4'd0, data: 32'd0});
      idle(4);

      // Divide by zero, then a consumer of r6 issued back-to-back.
      issue(5'd0, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 1'b1, 32'd0, 32'd5, 1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
      issue(5'd1, 4'd0, 4'd1, 4'd1, 32'd0, 1'b0, 1'b1, 32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
      issue(5'd3, 4'd6, 4'd1, 4'd0, 32'd0, 1'b1, 1'b1, 32'd5, 32'd0, 1'b1, Trap,
            Trap ? 32'd0 : 32'hFFFF_FFFF, 1'b1, Trap);
      issue(5'd0, 4'd7, 4'd6, 4'd0, 32'd0, 1'b1, 1'b1, Trap ? 32'd0 : 32'hFFFF_FFFF, 32'd0,
            1'b1, Trap, Trap ? 32'd0 : 32'hFFFF_FFFF, 1'b1, Trap);
      idle(3);

      for (int i = 0; i < 20 && (exp_e.size() + exp_wb.size() + exp_c.size()) != 0; i++)
         @(negedge clk);
      total++;
      if ((exp_e.size() + exp_wb.size() + exp_c.size()) != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, required 0",
                  exp_e.size() + exp_wb.size() + exp_c.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
